// File: rtl/ram_pkg.sv
// Shared types and default geometry for the single-port synchronous RAM.
// The controller is either clearing memory after reset or serving accesses.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int RAM_ADDR_WIDTH   = 8;
  localparam int RAM_DATA_WIDTH   = 16;
  localparam int RAM_READ_LATENCY = 1;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-latency pipeline: carries a valid bit LATENCY deep and the read word behind it.
// Stage 0 data is the RAM output register that lives in the top level.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int LATENCY    = RAM_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;

  always_comb begin
    valid_d    = '0;
    valid_d[0] = rd_en;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign dout_valid = valid_q[LATENCY-1];

  generate
    if (LATENCY == 1) begin : g_direct
      assign dout = rd_data;
    end else begin : g_staged
      logic [DATA_WIDTH-1:0] data_q [LATENCY-1];
      logic [DATA_WIDTH-1:0] data_d [LATENCY-1];

      // A stage only loads when a valid word arrives, so dout holds between reads.
      always_comb begin
        data_d[0] = valid_q[0] ? rd_data : data_q[0];
        for (int i = 1; i < LATENCY - 1; i++) begin
          data_d[i] = valid_q[i] ? data_q[i-1] : data_q[i];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            data_q[i] <= '0;
          end
        end else begin
          data_q <= data_d;
        end
      end

      assign dout = data_q[LATENCY-2];
    end
  endgenerate

endmodule

// File: rtl/single_port_ram_sync.sv
// Single-port synchronous RAM with byte enables, configurable read latency,
// and a hardware clear of every word after reset.
module single_port_ram_sync
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = RAM_DATA_WIDTH,
  parameter int READ_LATENCY = RAM_READ_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  ram_state_e            state_q;
  ram_state_e            state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic [ADDR_WIDTH-1:0] clr_addr_d;
  logic                  busy_q;
  logic                  busy_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_BYTES-1:0]  wr_be;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (&clr_addr_q) begin
          state_d    = READY;
          busy_d     = 1'b0;
          clr_addr_d = '0;
        end
      end
      READY: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  // The clear sweep owns the single write port; user accesses are ignored until it ends.
  always_comb begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = addr;
    wr_data = din;
    wr_be   = be;
    if (!rst) begin
      if (state_q == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_addr_q;
        wr_data = '0;
        wr_be   = '1;
      end else if (cs) begin
        wr_en = we;
        rd_en = !we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_data_d = rd_en ? mem[addr] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_data    (rd_data_q),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_single_port_ram_sync.sv
// Bench for single_port_ram_sync: one instance at read latency 1 and one at 2 share
// the same stimulus and are checked every cycle against a behavioural memory model.
module tb_single_port_ram_sync;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic [1:0]  be;
  logic [7:0]  addr;
  logic [15:0] din;

  logic [15:0] dout1;
  logic        dout_valid1;
  logic        busy1;
  logic [15:0] dout2;
  logic        dout_valid2;
  logic        busy2;

  int checks_total  = 0;
  int checks_passed = 0;
  int busy_cycles   = 0;
  bit busy_last     = 1'b0;
  logic [15:0] cap1[$];
  logic [15:0] cap2[$];

  single_port_ram_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout1), .dout_valid(dout_valid1), .busy(busy1)
  );

  single_port_ram_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout2), .dout_valid(dout_valid2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a word array, a clear countdown, and per-latency queues of
  // read results tagged with the cycle they must appear on.
  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_item_t;

  logic [15:0] model_mem [256];
  rd_item_t    q1[$];
  rd_item_t    q2[$];
  int          cyc        = 0;
  int          clear_left = 0;
  bit          model_live = 1'b0;
  logic        exp_busy   = 1'b1;
  logic        exp_valid1 = 1'b0;
  logic        exp_valid2 = 1'b0;
  logic [15:0] exp_dout1  = '0;
  logic [15:0] exp_dout2  = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      model_live = 1'b1;
      clear_left = 256;
      q1.delete();
      q2.delete();
      exp_busy   = 1'b1;
      exp_valid1 = 1'b0;
      exp_valid2 = 1'b0;
      exp_dout1  = '0;
      exp_dout2  = '0;
    end else begin
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0) begin
          foreach (model_mem[i]) model_mem[i] = '0;
        end
      end else if (cs) begin
        if (we) begin
          for (int b = 0; b < 2; b++) begin
            if (be[b]) model_mem[addr][8*b +: 8] = din[8*b +: 8];
          end
        end else begin
          q1.push_back('{cyc, model_mem[addr]});
          q2.push_back('{cyc + 1, model_mem[addr]});
        end
      end
      exp_busy   = (clear_left > 0);
      exp_valid1 = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        exp_valid1 = 1'b1;
        exp_dout1  = q1[0].data;
        void'(q1.pop_front());
      end
      exp_valid2 = 1'b0;
      if (q2.size() > 0 && q2[0].due == cyc) begin
        exp_valid2 = 1'b1;
        exp_dout2  = q2[0].data;
        void'(q2.pop_front());
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Sample on the falling edge, compare against the model, and log read pulses.
  task automatic tickCheck();
    @(negedge clk);
    if (model_live) begin
      checkOutput("busy_l1", busy1, exp_busy);
      checkOutput("busy_l2", busy2, exp_busy);
      checkOutput("valid_l1", dout_valid1, exp_valid1);
      checkOutput("valid_l2", dout_valid2, exp_valid2);
      checkOutput("dout_l1", dout1, exp_dout1);
      checkOutput("dout_l2", dout2, exp_dout2);
    end
    busy_last = (busy1 === 1'b1);
    if (busy1 === 1'b1) busy_cycles++;
    if (dout_valid1 === 1'b1) cap1.push_back(dout1);
    if (dout_valid2 === 1'b1) cap2.push_back(dout2);
  endtask

  task automatic driveInputs(input logic r, input logic c, input logic w,
                             input logic [1:0] b, input logic [7:0] a, input logic [15:0] d);
    rst  = r;
    cs   = c;
    we   = w;
    be   = b;
    addr = a;
    din  = d;
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic w,
                               input logic [1:0] b, input logic [7:0] a, input logic [15:0] d);
    tickCheck();
    driveInputs(r, c, w, b, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
  endtask

  task automatic clearCaps();
    cap1.delete();
    cap2.delete();
  endtask

  task automatic checkReads(input string tag, input int n, input logic [15:0] e0,
                            input logic [15:0] e1, input logic [15:0] e2);
    logic [15:0] e[3];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    checkOutput({tag, "_count_l1"}, cap1.size(), n);
    checkOutput({tag, "_count_l2"}, cap2.size(), n);
    for (int i = 0; i < n && i < cap1.size(); i++)
      checkOutput($sformatf("%s_l1_%0d", tag, i), cap1[i], e[i]);
    for (int i = 0; i < n && i < cap2.size(); i++)
      checkOutput($sformatf("%s_l2_%0d", tag, i), cap2[i], e[i]);
  endtask

  // Hold reset, release it, then count busy samples from the release cycle onward.
  task automatic resetAndClear(input int hold, input logic attack);
    for (int i = 0; i < hold; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    busy_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      tickCheck();
      if (i == 0) begin
        checkOutput("rst_dout_l1", dout1, 16'h0000);
        checkOutput("rst_dout_l2", dout2, 16'h0000);
        checkOutput("rst_busy", busy1, 1);
      end
      if (!busy_last) begin
        driveInputs(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        break;
      end
      driveInputs(1'b0, attack, attack, 2'b11, 8'h20, 16'hFFFF);
    end
    checkOutput("clear_cycles", busy_cycles, 256);
  endtask

  initial begin
    driveInputs(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);

    // Power-up clear with a write to 0x20 attempted throughout.
    clearCaps();
    resetAndClear(3, 1'b1);
    checkOutput("no_valid_in_clear_l1", cap1.size(), 0);
    checkOutput("no_valid_in_clear_l2", cap2.size(), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h20, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h9C, 16'h0000);
    idle(4);
    checkReads("after_clear", 2, 16'h0000, 16'h0000, 16'h0000);

    // Three writes then back-to-back reads.
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 8'h05, 16'hAAAA);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 8'h06, 16'h5555);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 8'h07, 16'hF00D);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h05, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h06, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h07, 16'h0000);
    idle(4);
    checkReads("b2b", 3, 16'hAAAA, 16'h5555, 16'hF00D);

    // Partial byte write merges with the old word.
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 8'h10, 16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 8'h10, 16'hABCD);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h10, 16'h0000);
    idle(4);
    checkReads("byte_en", 1, 16'hAB34, 16'h0000, 16'h0000);

    // be=0 write and a deselected write must both leave 0x05 alone.
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 8'h05, 16'h1111);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 8'h05, 16'h0000);
    idle(3);
    checkOutput("hold_l1", dout1, 16'hAB34);
    checkOutput("hold_l2", dout2, 16'hAB34);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h05, 16'h0000);
    idle(4);
    checkReads("cs_low", 1, 16'hAAAA, 16'h0000, 16'h0000);

    // Randomised traffic over a small address window plus the top word.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                    16'($urandom()));
    end
    idle(4);

    // Read followed immediately by reset; the latency-2 result must be dropped.
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h06, 16'h0000);
    resetAndClear(5, 1'b0);
    checkOutput("rst_flight_l1", cap1.size(), 1);
    checkOutput("rst_flight_l2", cap2.size(), 0);
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h06, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h10, 16'h0000);
    idle(4);
    checkReads("after_reclear", 2, 16'h0000, 16'h0000, 16'h0000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/single_port_ram_sync.md
SINGLE_PORT_RAM_SYNC -- requirements
Module: single_port_ram_sync

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word address width; depth = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 16, word width; SHALL be a multiple of 8.
REQ-003 Parameter READ_LATENCY, default 1, legal values 1 or 2; clocks from read request to dout_valid.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cs  input  1  chip select; no access when low.
REQ-007 we  input  1  write enable (1 = write, 0 = read), qualified by cs.
REQ-008 be  input  DATA_WIDTH/8  byte enables for writes; bit i covers din[8i+7:8i].
REQ-009 addr  input  ADDR_WIDTH  word address.
REQ-010 din  input  DATA_WIDTH  write data.
REQ-011 dout  output  DATA_WIDTH  registered read data.
REQ-012 dout_valid  output  1  one-cycle pulse, dout holds fresh read data.
REQ-013 busy  output  1  high while the post-reset memory clear runs.

Function
REQ-014 Controller SHALL have two states: CLEAR and READY.
REQ-015 CLEAR: writes all-zero to word clr_addr each cycle, clr_addr counting 0 upward; busy=1.
REQ-016 CLEAR->READY on the cycle that clears word depth-1; clear SHALL take exactly 2**ADDR_WIDTH cycles.
REQ-017 In CLEAR, cs/we/addr/din/be SHALL be ignored; no write, no dout_valid.
REQ-018 READY, cs=1 we=1: bytes with be[i]=1 written at addr on the edge; bytes with be[i]=0 unchanged; be=0 is a no-op.
REQ-019 READY, cs=1 we=0: read of addr; data on dout with dout_valid=1 exactly READ_LATENCY cycles later.
REQ-020 Back-to-back reads every cycle SHALL be accepted; one dout_valid per read, in order.
REQ-021 Write then read of the same address in the next cycle SHALL return the newly written data.
REQ-022 A write cycle SHALL NOT produce dout_valid and SHALL NOT change dout.
REQ-023 cs=0: no memory change; dout holds its last value; dout_valid=0 for that slot.
REQ-024 Address wrap: none internally; addr is ADDR_WIDTH bits, so every value is legal.

Reset
REQ-025 rst=1 on an edge: state<=CLEAR, clr_addr<=0, busy<=1, dout<=0, dout_valid<=0, read pipeline valid bits<=0.
REQ-026 rst during READY SHALL discard in-flight reads (no dout_valid) and restart a full clear.
REQ-027 rst during CLEAR SHALL restart the clear from address 0.
REQ-028 rst held high SHALL keep busy=1 and the controller at clr_addr=0.

Structure
REQ-029 Shared package ram_pkg SHALL hold the state enum (CLEAR, READY) and the default parameter constants.
REQ-030 Read-latency pipeline (data + valid, depth READ_LATENCY) SHALL be sub-module ram_rd_pipe.
REQ-031 Storage SHALL be a single register array, one write port and one read port, inferable as block RAM.

Verification
REQ-032 Reset, ADDR_WIDTH=8: busy=1 for exactly 256 cycles after rst falls, then 0; read any addr -> 0x0000.
REQ-033 Write 0x05=AAAA, 0x06=5555, 0x07=F00D with be=11, then read 05,06,07 back-to-back -> dout AAAA,5555,F00D on three consecutive dout_valid pulses, at READ_LATENCY=1 and 2.
REQ-034 Write 0x10=1234 (be=11), then write 0x10=ABCD with be=10, read -> AB34.
REQ-035 Access attempted while busy=1 (write 0x20=FFFF) -> after clear, read 0x20 -> 0000; no dout_valid during CLEAR.
REQ-036 Issue read, assert rst next cycle -> no dout_valid, busy rises, dout=0, full 256-cycle clear repeats.
REQ-037 cs=0 with we=1 at 0x05 -> contents unchanged (read returns AAAA); dout holds and dout_valid stays 0 while cs=0.
